// File: rtl/vga_frame_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// vga_frame_scheduler_pkg
//   Shared types and default raster constants for the VGA frame scheduler.
//   - sched_state_t : scheduler phase (SYNC / DRAW / UPDATE / DRAIN)
//   - *_DEF         : default 640x480 timing constants
//   - at_line_start : exact-equality test for "column 0 of a given line"
// -----------------------------------------------------------------------------
package vga_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DRAIN  = 2'd3
  } sched_state_t;

  localparam int H_ACTIVE_DEF    = 640;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int V_TOTAL_DEF     = 525;
  localparam int GUARD_LINES_DEF = 2;
  localparam int POS_W           = 10;

  // True only on the exact pixel (line, 0); any other coordinate is ignored.
  function automatic logic at_line_start(input logic [POS_W-1:0] row,
                                         input logic [POS_W-1:0] col,
                                         input logic [POS_W-1:0] line);
    return (row == line) && (col == '0);
  endfunction

endpackage

// File: rtl/vga_frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// vga_frame_scheduler_if
//   Bundles the renderer port, the game-logic port and the object-table RAM
//   port of the frame scheduler.
//   master : request side (renderer, game logic) and RAM observer
//   slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface vga_frame_scheduler_if #(
  parameter int AW = 6,
  parameter int DW = 32
);

  logic          rnd_req;
  logic [AW-1:0] rnd_addr;
  logic          rnd_rvalid;

  logic          game_req;
  logic          game_we;
  logic [AW-1:0] game_addr;
  logic [DW-1:0] game_wdata;
  logic          game_ack;
  logic          game_rvalid;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  modport master (
    output rnd_req, rnd_addr,
    output game_req, game_we, game_addr, game_wdata,
    input  rnd_rvalid, game_ack, game_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rnd_req, rnd_addr,
    input  game_req, game_we, game_addr, game_wdata,
    output rnd_rvalid, game_ack, game_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vga_frame_scheduler_pos_events.sv
// -----------------------------------------------------------------------------
// vga_frame_scheduler_pos_events
//   Decodes the raster position from the timing generator into the three
//   frame events the scheduler reacts to. Each is high only on the exact
//   coordinate, so a skipped coordinate simply produces no event.
//   Ports:
//     col_i, row_i   : current raster position
//     o_sof          : row 0, col 0
//     o_vblank_start : row V_ACTIVE, col 0
//     o_guard_start  : row V_TOTAL-GUARD_LINES, col 0
// -----------------------------------------------------------------------------
module vga_frame_scheduler_pos_events
  import vga_frame_scheduler_pkg::*;
#(
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int GUARD_LINES = GUARD_LINES_DEF
) (
  input  logic [POS_W-1:0] col_i,
  input  logic [POS_W-1:0] row_i,
  output logic             o_sof,
  output logic             o_vblank_start,
  output logic             o_guard_start
);

  localparam logic [POS_W-1:0] ROW_VBLANK = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] ROW_GUARD  = POS_W'(V_TOTAL - GUARD_LINES);

  assign o_sof          = at_line_start(row_i, col_i, '0);
  assign o_vblank_start = at_line_start(row_i, col_i, ROW_VBLANK);
  assign o_guard_start  = at_line_start(row_i, col_i, ROW_GUARD);

endmodule

// File: rtl/vga_frame_scheduler.sv
// -----------------------------------------------------------------------------
// vga_frame_scheduler
//   Owns the single port of the shared object-table RAM. The renderer reads
//   during active video (DRAW); game logic gets req/ack access only inside the
//   vertical-blank update window (UPDATE); the last GUARD_LINES lines of the
//   blank (DRAIN) accept nothing new but let in-flight reads return.
//   Ports:
//     clk, reset            : pixel clock, async active-high reset
//     col_i, row_i          : raster position from the timing generator
//     bus (slave)           : renderer / game / RAM signals
//     frame_tick            : one-cycle pulse at start of vblank
//     frame_cnt             : completed frames, wraps
//     upd_window            : high while in the update window
//     overrun, overrun_clr  : sticky "game request left pending" flag + clear
// -----------------------------------------------------------------------------
module vga_frame_scheduler
  import vga_frame_scheduler_pkg::*;
#(
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int GUARD_LINES = GUARD_LINES_DEF,
  parameter int AW          = 6,
  parameter int DW          = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [POS_W-1:0]   col_i,
  input  logic [POS_W-1:0]   row_i,
  vga_frame_scheduler_if.slave bus,
  output logic               frame_tick,
  output logic [15:0]        frame_cnt,
  output logic               upd_window,
  output logic               overrun,
  input  logic               overrun_clr
);

  sched_state_t  r_state;
  logic          r_frame_tick;
  logic [15:0]   r_frame_cnt;
  logic          r_upd_window;
  logic          r_overrun;
  logic          r_game_ack;
  logic          r_mem_en;
  logic          r_mem_we;
  logic          r_mem_src_game;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_rnd_rvalid;
  logic          r_game_rvalid;

  logic w_sof;
  logic w_vblank_start;
  logic w_guard_start;
  logic w_game_pending;
  logic w_rnd_rd;
  logic w_game_grant;
  logic w_ovr_set;

  vga_frame_scheduler_pos_events #(
    .V_ACTIVE    (V_ACTIVE),
    .V_TOTAL     (V_TOTAL),
    .GUARD_LINES (GUARD_LINES)
  ) u_pos_events (
    .col_i          (col_i),
    .row_i          (row_i),
    .o_sof          (w_sof),
    .o_vblank_start (w_vblank_start),
    .o_guard_start  (w_guard_start)
  );

  // A request seen while its ack is on the wire is the same request, so it is
  // never re-accepted; this also limits game traffic to one access per 2 cycles.
  assign w_game_pending = bus.game_req && !r_game_ack;
  assign w_rnd_rd       = (r_state == ST_DRAW) && bus.rnd_req;
  // The window-closing cycle grants nothing; a pending request there is an overrun.
  assign w_game_grant   = (r_state == ST_UPDATE) && !w_guard_start && w_game_pending;
  assign w_ovr_set      = (r_state == ST_UPDATE) &&  w_guard_start && w_game_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_SYNC;
      r_frame_tick   <= 1'b0;
      r_frame_cnt    <= '0;
      r_upd_window   <= 1'b0;
      r_overrun      <= 1'b0;
      r_game_ack     <= 1'b0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_src_game <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_rnd_rvalid   <= 1'b0;
      r_game_rvalid  <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      r_game_ack   <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;

      // RAM read data arrives one cycle after the enable; tag it by requester.
      r_rnd_rvalid  <= r_mem_en && !r_mem_we && !r_mem_src_game;
      r_game_rvalid <= r_mem_en && !r_mem_we &&  r_mem_src_game;

      if (w_rnd_rd) begin
        r_mem_en       <= 1'b1;
        r_mem_src_game <= 1'b0;
        r_mem_addr     <= bus.rnd_addr;
      end else if (w_game_grant) begin
        r_game_ack     <= 1'b1;
        r_mem_en       <= 1'b1;
        r_mem_we       <= bus.game_we;
        r_mem_src_game <= 1'b1;
        r_mem_addr     <= bus.game_addr;
        r_mem_wdata    <= bus.game_wdata;
      end

      // Set has priority over a simultaneous clear.
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        ST_SYNC: begin
          if (w_sof) r_state <= ST_DRAW;
        end
        ST_DRAW: begin
          if (w_vblank_start) begin
            r_state      <= ST_UPDATE;
            r_upd_window <= 1'b1;
            r_frame_tick <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
          end
        end
        ST_UPDATE: begin
          if (w_guard_start) begin
            r_state      <= ST_DRAIN;
            r_upd_window <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_sof) r_state <= ST_DRAW;
        end
        default: begin
          r_state <= ST_SYNC;
        end
      endcase
    end
  end

  assign bus.rnd_rvalid  = r_rnd_rvalid;
  assign bus.game_ack    = r_game_ack;
  assign bus.game_rvalid = r_game_rvalid;
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign frame_tick      = r_frame_tick;
  assign frame_cnt       = r_frame_cnt;
  assign upd_window      = r_upd_window;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_scheduler
//   Drives raster coordinates directly (jumping between frame event points),
//   plus renderer/game requests, and compares every cycle against a
//   behavioural model of the scheduling rules. A fixed vector table covers the
//   basic frame walk; hand sequences cover reset, overrun priority, glitches
//   and frame-counter wrap; a random phase finishes.
// -----------------------------------------------------------------------------
module tb_vga_frame_scheduler;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam logic [9:0] ROW_VB = 10'd480;
  localparam logic [9:0] ROW_GD = 10'd523;
  localparam int M_SYNC = 0, M_DRAW = 1, M_UPDATE = 2, M_DRAIN = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  col_i, row_i;
  logic        overrun_clr;
  logic        frame_tick;
  logic [15:0] frame_cnt;
  logic        upd_window;
  logic        overrun;

  vga_frame_scheduler_if #(.AW(AW), .DW(DW)) bus();

  vga_frame_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .col_i       (col_i),
    .row_i       (row_i),
    .bus         (bus),
    .frame_tick  (frame_tick),
    .frame_cnt   (frame_cnt),
    .upd_window  (upd_window),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  row, col;
    logic        rnd_req;
    logic [5:0]  rnd_addr;
    logic        game_req, game_we;
    logic [5:0]  game_addr;
    logic [31:0] game_wdata;
    logic        clr;
  } in_t;

  typedef struct {
    logic        tick;
    logic [15:0] cnt;
    logic        upd, ack, men, mwe;
    logic [5:0]  maddr;
    logic        rrv, grv, ovr;
  } ex_t;

  int n_vec = 0;
  int n_bad = 0;
  int n_cmp = 0;

  // behavioural model state
  int          m_mode;
  logic [15:0] m_cnt;
  bit          m_ov, m_ack, m_upd, m_tick, m_men, m_mwe;
  logic [5:0]  m_maddr;
  logic [31:0] m_mwdata;
  int          rq[$];
  int          gq[$];

  function automatic in_t mk_in(int row, int col, bit rr, int ra, bit gr, bit gw,
                                int ga, logic [31:0] gd, bit clr);
    in_t v;
    v.row = 10'(row); v.col = 10'(col);
    v.rnd_req = rr; v.rnd_addr = 6'(ra);
    v.game_req = gr; v.game_we = gw; v.game_addr = 6'(ga); v.game_wdata = gd;
    v.clr = clr;
    return v;
  endfunction

  function automatic ex_t mk_ex(bit tick, int cnt, bit upd, bit ack, bit men, bit mwe,
                                int maddr, bit rrv, bit grv, bit ovr);
    ex_t e;
    e.tick = tick; e.cnt = 16'(cnt); e.upd = upd; e.ack = ack; e.men = men;
    e.mwe = mwe; e.maddr = 6'(maddr); e.rrv = rrv; e.grv = grv; e.ovr = ovr;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at vector %0d: got %0h, expected %0h", nm, n_vec, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_SYNC; m_cnt = '0; m_ov = 0; m_ack = 0; m_upd = 0; m_tick = 0;
    m_men = 0; m_mwe = 0; m_maddr = '0; m_mwdata = '0;
    rq.delete(); gq.delete();
  endtask

  // Advance the model by one clock given the inputs present before the edge.
  task automatic model_step(in_t v, int k);
    bit sof, vbs, grd, rd, pend, gr;
    int nm;
    sof  = (v.row == 10'd0)  && (v.col == 10'd0);
    vbs  = (v.row == ROW_VB) && (v.col == 10'd0);
    grd  = (v.row == ROW_GD) && (v.col == 10'd0);
    rd   = (m_mode == M_DRAW) && v.rnd_req;
    pend = v.game_req && !m_ack;
    gr   = (m_mode == M_UPDATE) && !grd && pend;
    nm = m_mode;
    if (m_mode == M_SYNC   && sof) nm = M_DRAW;
    if (m_mode == M_DRAW   && vbs) nm = M_UPDATE;
    if (m_mode == M_UPDATE && grd) nm = M_DRAIN;
    if (m_mode == M_DRAIN  && sof) nm = M_DRAW;
    m_tick = (m_mode == M_DRAW) && vbs;
    if (m_tick) m_cnt = m_cnt + 16'd1;
    if ((m_mode == M_UPDATE) && grd && pend) m_ov = 1;
    else if (v.clr) m_ov = 0;
    m_ack = gr;
    m_men = rd || gr;
    m_mwe = gr && v.game_we;
    if (rd) m_maddr = v.rnd_addr;
    if (gr) begin m_maddr = v.game_addr; m_mwdata = v.game_wdata; end
    // reads are returned one observation after their enable
    if (rd) rq.push_back(k + 1);
    if (gr && !v.game_we) gq.push_back(k + 1);
    m_upd = (nm == M_UPDATE);
    m_mode = nm;
  endtask

  task automatic drive(in_t v);
    row_i = v.row; col_i = v.col;
    bus.rnd_req = v.rnd_req; bus.rnd_addr = v.rnd_addr;
    bus.game_req = v.game_req; bus.game_we = v.game_we;
    bus.game_addr = v.game_addr; bus.game_wdata = v.game_wdata;
    overrun_clr = v.clr;
  endtask

  task automatic apply(in_t v);
    bit erv, egv;
    int k;
    k = n_vec;
    drive(v);
    model_step(v, k);
    @(posedge clk);
    #1;
    erv = (rq.size() > 0) && (rq[0] == k);
    if (erv) void'(rq.pop_front());
    egv = (gq.size() > 0) && (gq[0] == k);
    if (egv) void'(gq.pop_front());
    chk("frame_tick",  32'(frame_tick),      32'(m_tick));
    chk("frame_cnt",   32'(frame_cnt),       32'(m_cnt));
    chk("upd_window",  32'(upd_window),      32'(m_upd));
    chk("game_ack",    32'(bus.game_ack),    32'(m_ack));
    chk("mem_en",      32'(bus.mem_en),      32'(m_men));
    chk("rnd_rvalid",  32'(bus.rnd_rvalid),  32'(erv));
    chk("game_rvalid", 32'(bus.game_rvalid), 32'(egv));
    chk("overrun",     32'(overrun),         32'(m_ov));
    if (m_men) begin
      chk("mem_we",   32'(bus.mem_we),   32'(m_mwe));
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_maddr));
      if (m_mwe) chk("mem_wdata", bus.mem_wdata, m_mwdata);
    end
    n_vec++;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_tick"},   32'(frame_tick),      0);
    chk({tag, "_cnt"},    32'(frame_cnt),       0);
    chk({tag, "_upd"},    32'(upd_window),      0);
    chk({tag, "_ovr"},    32'(overrun),         0);
    chk({tag, "_ack"},    32'(bus.game_ack),    0);
    chk({tag, "_men"},    32'(bus.mem_en),      0);
    chk({tag, "_mwe"},    32'(bus.mem_we),      0);
    chk({tag, "_maddr"},  32'(bus.mem_addr),    0);
    chk({tag, "_mwdata"}, bus.mem_wdata,        0);
    chk({tag, "_rrv"},    32'(bus.rnd_rvalid),  0);
    chk({tag, "_grv"},    32'(bus.game_rvalid), 0);
  endtask

  in_t idle;
  in_t ti[16];
  ex_t te[16];

  initial begin
    idle = mk_in(1, 5, 0, 0, 0, 0, 0, 32'h0, 0);
    drive(idle);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // ---------------- table: frame walk, renderer read, game accesses, overrun
    ti[0]  = mk_in(1, 5,   0, 0,  0, 0, 0, 32'h0, 0);        te[0]  = mk_ex(0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    ti[1]  = mk_in(0, 0,   0, 0,  0, 0, 0, 32'h0, 0);        te[1]  = mk_ex(0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    ti[2]  = mk_in(0, 1,   1, 5,  1, 1, 3, 32'hDEADBEEF, 0); te[2]  = mk_ex(0, 0, 0, 0, 1, 0, 5,  0, 0, 0);
    ti[3]  = mk_in(0, 2,   0, 0,  1, 1, 3, 32'hDEADBEEF, 0); te[3]  = mk_ex(0, 0, 0, 0, 0, 0, 0,  1, 0, 0);
    ti[4]  = mk_in(100, 3, 0, 0,  1, 1, 3, 32'hDEADBEEF, 0); te[4]  = mk_ex(0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    ti[5]  = mk_in(480, 0, 0, 0,  1, 1, 3, 32'hDEADBEEF, 0); te[5]  = mk_ex(1, 1, 1, 0, 0, 0, 0,  0, 0, 0);
    ti[6]  = mk_in(480, 1, 0, 0,  1, 1, 3, 32'hDEADBEEF, 0); te[6]  = mk_ex(0, 1, 1, 1, 1, 1, 3,  0, 0, 0);
    ti[7]  = mk_in(480, 2, 0, 0,  1, 1, 3, 32'hDEADBEEF, 0); te[7]  = mk_ex(0, 1, 1, 0, 0, 0, 0,  0, 0, 0);
    ti[8]  = mk_in(480, 3, 0, 0,  1, 0, 7, 32'h0, 0);        te[8]  = mk_ex(0, 1, 1, 1, 1, 0, 7,  0, 0, 0);
    ti[9]  = mk_in(480, 4, 0, 0,  0, 0, 0, 32'h0, 0);        te[9]  = mk_ex(0, 1, 1, 0, 0, 0, 0,  0, 1, 0);
    ti[10] = mk_in(523, 0, 0, 0,  1, 0, 9, 32'h0, 0);        te[10] = mk_ex(0, 1, 0, 0, 0, 0, 0,  0, 0, 1);
    ti[11] = mk_in(523, 1, 0, 0,  1, 0, 9, 32'h0, 0);        te[11] = mk_ex(0, 1, 0, 0, 0, 0, 0,  0, 0, 1);
    ti[12] = mk_in(523, 2, 0, 0,  0, 0, 0, 32'h0, 1);        te[12] = mk_ex(0, 1, 0, 0, 0, 0, 0,  0, 0, 0);
    ti[13] = mk_in(0, 0,   0, 0,  0, 0, 0, 32'h0, 0);        te[13] = mk_ex(0, 1, 0, 0, 0, 0, 0,  0, 0, 0);
    ti[14] = mk_in(10, 10, 1, 63, 0, 0, 0, 32'h0, 0);        te[14] = mk_ex(0, 1, 0, 0, 1, 0, 63, 0, 0, 0);
    ti[15] = mk_in(10, 11, 0, 0,  0, 0, 0, 32'h0, 0);        te[15] = mk_ex(0, 1, 0, 0, 0, 0, 0,  1, 0, 0);

    for (int i = 0; i < 16; i++) begin
      apply(ti[i]);
      chk("tbl_tick", 32'(frame_tick),      32'(te[i].tick));
      chk("tbl_cnt",  32'(frame_cnt),       32'(te[i].cnt));
      chk("tbl_upd",  32'(upd_window),      32'(te[i].upd));
      chk("tbl_ack",  32'(bus.game_ack),    32'(te[i].ack));
      chk("tbl_men",  32'(bus.mem_en),      32'(te[i].men));
      chk("tbl_rrv",  32'(bus.rnd_rvalid),  32'(te[i].rrv));
      chk("tbl_grv",  32'(bus.game_rvalid), 32'(te[i].grv));
      chk("tbl_ovr",  32'(overrun),         32'(te[i].ovr));
      if (te[i].men) begin
        chk("tbl_mwe",   32'(bus.mem_we),   32'(te[i].mwe));
        chk("tbl_maddr", 32'(bus.mem_addr), 32'(te[i].maddr));
      end
      if (te[i].men && te[i].mwe) chk("tbl_mwdata", bus.mem_wdata, 32'hDEADBEEF);
    end

    // ---------------- glitch: near-miss coordinates must not advance DRAW
    apply(mk_in(479, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    apply(mk_in(480, 1, 0, 0, 0, 0, 0, 32'h0, 0));
    apply(mk_in(481, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    chk("glitch_upd", 32'(upd_window), 0);
    chk("glitch_cnt", 32'(frame_cnt), 1);

    // ---------------- overrun set and clear in the same cycle: set wins
    apply(mk_in(480, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    apply(mk_in(523, 0, 0, 0, 1, 1, 2, 32'h0, 1));
    chk("set_wins", 32'(overrun), 1);
    apply(mk_in(523, 1, 0, 0, 0, 0, 0, 32'h0, 1));
    chk("clr_after", 32'(overrun), 0);

    // ---------------- async reset in the middle of an UPDATE access
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    apply(mk_in(480, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    apply(mk_in(480, 1, 0, 0, 1, 1, 4, 32'h12345678, 0));
    chk("pre_rst_ack", 32'(bus.game_ack), 1);
    reset = 1'b1;
    #2;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    apply(mk_in(480, 0, 0, 0, 1, 1, 4, 32'h1, 0));
    apply(mk_in(480, 1, 0, 0, 1, 1, 4, 32'h1, 0));
    chk("rst_noack", 32'(bus.game_ack), 0);
    chk("rst_notick", 32'(frame_cnt), 0);
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    apply(mk_in(480, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    chk("rst_redraw", 32'(frame_cnt), 1);

    // ---------------- frame counter wrap
    apply(mk_in(523, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    force dut.r_frame_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    apply(idle);
    release dut.r_frame_cnt;
    apply(idle);
    apply(mk_in(480, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    chk("wrap_cnt",  32'(frame_cnt),  0);
    chk("wrap_tick", 32'(frame_tick), 1);

    // ---------------- randomized traffic
    for (int i = 0; i < 4000; i++) begin
      in_t v;
      int sel;
      sel = int'($urandom_range(0, 19));
      case (sel)
        0:       begin v.row = 10'd0;   v.col = 10'd0; end
        1:       begin v.row = ROW_VB;  v.col = 10'd0; end
        2:       begin v.row = ROW_GD;  v.col = 10'd0; end
        3:       begin v.row = 10'($urandom_range(478, 525)); v.col = 10'($urandom_range(0, 1)); end
        default: begin v.row = 10'($urandom_range(0, 524)); v.col = 10'($urandom_range(1, 799)); end
      endcase
      v.rnd_req    = 1'($urandom_range(0, 1));
      v.rnd_addr   = 6'($urandom);
      v.game_req   = ($urandom_range(0, 3) != 0);
      v.game_we    = 1'($urandom_range(0, 1));
      v.game_addr  = 6'($urandom);
      v.game_wdata = $urandom;
      v.clr        = ($urandom_range(0, 15) == 0);
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
